if_fetch_unit: RTL

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit_pkg.sv | 19 +
 rtl/if_perf_counter.sv | 15 +
 rtl/if_fetch_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared fetch-unit defines, constants and FSM encoding
`ifndef IF_FETCH_UNIT_DEFINES
`define IF_FETCH_UNIT_DEFINES
`define INST_NOP 32'h0000_0013
`define PC_RST   32'h0000_0000
`endif

package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INST_NOP_C = `INST_NOP;
  localparam logic [31:0] PC_RST_C   = `PC_RST;

endpackage

// File: rtl/if_perf_counter.sv
// rtl/if_perf_counter.sv - 32-bit wrapping event counter with enable
module if_perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] count
);

  // count enabled cycles, wrapping naturally at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else if (en) count <= count + 32'd1;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch unit with one outstanding request; IF_FETCH_PERF_EN enables perf counters
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_if,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instr_if,
  output logic [WIDTH-1:0] pc_if,
  output logic [WIDTH-1:0] pc_plus4_if,
  output logic             if_bubble,
  output logic [31:0]      perf_fetch_cnt,
  output logic [31:0]      perf_bubble_cnt
);

  localparam logic [WIDTH-1:0] NOP_W    = WIDTH'(`INST_NOP);
  localparam logic [WIDTH-1:0] PC_RST_W = WIDTH'(`PC_RST);

  fetch_state_t     state, state_n;
  logic [WIDTH-1:0] pc, pc_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic             kill, kill_n;

  assign imem_addr   = pc;
  assign pc_if       = pc;
  assign pc_plus4_if = pc + WIDTH'(4);

  // state, pc, kill flag and held instruction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_REQ;
      pc    <= PC_RST_W;
      hold  <= NOP_W;
      kill  <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      hold  <= hold_n;
      kill  <= kill_n;
    end
  end

  // next-state and outputs; redirect outranks stall and memory events
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    hold_n    = hold;
    kill_n    = kill;
    imem_req  = 1'b0;
    instr_if  = NOP_W;
    if_bubble = 1'b1;
    case (state)
      ST_REQ: begin
        // a late response from a request abandoned by reset lands here and is ignored
        imem_req = ~redirect_valid & ~rst;
        if (redirect_valid) begin
          pc_n = redirect_pc;
        end else if (imem_ready) begin
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_n = redirect_pc;
          if (imem_rvalid) begin
            kill_n  = 1'b0;
            state_n = ST_REQ;
          end else begin
            kill_n = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill) begin
            kill_n  = 1'b0;
            state_n = ST_REQ;
          end else begin
            instr_if  = imem_rdata;
            if_bubble = 1'b0;
            if (stall_if) begin
              hold_n  = imem_rdata;
              state_n = ST_HOLD;
            end else begin
              pc_n    = pc + WIDTH'(4);
              state_n = ST_REQ;
            end
          end
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_n    = redirect_pc;
          hold_n  = NOP_W;
          state_n = ST_REQ;
        end else begin
          instr_if  = hold;
          if_bubble = 1'b0;
          if (!stall_if) begin
            pc_n    = pc + WIDTH'(4);
            state_n = ST_REQ;
          end
        end
      end
      default: state_n = ST_REQ;
    endcase
  end

`ifdef IF_FETCH_PERF_EN
  if_perf_counter u_fetch_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (~if_bubble & ~stall_if),
    .count (perf_fetch_cnt)
  );

  if_perf_counter u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (if_bubble),
    .count (perf_bubble_cnt)
  );
`else
  assign perf_fetch_cnt  = 32'd0;
  assign perf_bubble_cnt = 32'd0;
`endif

endmodule
